maxpool_frame_sequencer: RTL and testbench

Controller that drives one streaming 3x3 max-pool engine (line-buffer based, zero-padded, strided) through a multi-channel feature map. It pops pixels from an upstream first-word-fall-through FIFO, feeds them to the engine one per cycle, and pushes drain pixels so the last row is evaluated. It counts pooled results and clears the engine between channels. It sits between the layer's input FIFO and output FIFO and is the only block that toggles the engine's Valid_IN and CLR.

---
 rtl/maxpool_frame_sequencer_if.sv | 26 ++
 rtl/maxpool_frame_sequencer.sv | 160 ++++++++++++++++
 tb/tb_maxpool_frame_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_frame_sequencer_if.sv
// FIFO, pool-engine and output-FIFO signals between the frame sequencer and its neighbours.
// master = sequencer side, slave = FIFO/engine/output side.
interface maxpool_frame_sequencer_if #(
    parameter int Datawidth = 16
);
    logic                 Fifo_Rd;
    logic                 Fifo_Empty;
    logic [Datawidth-1:0] Fifo_Data;
    logic [Datawidth-1:0] Pool_In;
    logic                 Pool_Valid_IN;
    logic                 Pool_CLR;
    logic                 Pool_Valid_OUT;
    logic [Datawidth-1:0] Pool_Out;
    logic [Datawidth-1:0] Out_Data;
    logic                 Out_Valid;

    modport master (
        input  Fifo_Data, Fifo_Empty, Pool_Valid_OUT, Pool_Out,
        output Fifo_Rd, Pool_In, Pool_Valid_IN, Pool_CLR, Out_Data, Out_Valid
    );

    modport slave (
        output Fifo_Data, Fifo_Empty, Pool_Valid_OUT, Pool_Out,
        input  Fifo_Rd, Pool_In, Pool_Valid_IN, Pool_CLR, Out_Data, Out_Valid
    );
endinterface

// File: rtl/maxpool_frame_sequencer.sv
// Drives a streaming 3x3 max-pool engine channel by channel: clear, feed, flush, collect results.
// Defining POOL_SEQ_TIMEOUT_EN adds a result-wait watchdog that raises Error and ends the run.
module maxpool_frame_sequencer #(
    parameter int IMG_Width    = 3,
    parameter int IMG_Height   = 3,
    parameter int Datawidth    = 16,
    parameter int Stride       = 2,
    parameter int Max_Channels = 64,
    parameter int Timeout      = 1024
) (
    input  logic                              CLK,
    input  logic                              CLR,
    input  logic                              Start,
    input  logic [$clog2(Max_Channels+1)-1:0] Num_Channels,
    output logic                              Busy,
    output logic                              Done,
    output logic                              Error,
    maxpool_frame_sequencer_if.master         bus
);
    localparam int N_PIX   = IMG_Width * IMG_Height;
    localparam int N_FLUSH = IMG_Width + 1;
    localparam int N_OUT   = ((IMG_Width + Stride - 1) / Stride) * ((IMG_Height + Stride - 1) / Stride);
    localparam int CH_W    = $clog2(Max_Channels + 1);
    localparam int PIX_W   = $clog2(N_PIX + 1);
    localparam int OUT_W   = $clog2(N_OUT + 1);
    localparam int FL_W    = $clog2(N_FLUSH + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_FEED   = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    logic [2:0]       state;
    logic [CH_W-1:0]  num_ch;
    logic [CH_W-1:0]  ch_cnt;
    logic [CH_W-1:0]  ch_next;
    logic [PIX_W-1:0] pix_cnt;
    logic [OUT_W-1:0] out_cnt;
    logic [FL_W-1:0]  flush_cnt;
    logic             pop;
    logic             accept;
    logic             out_full;
    logic             timed_out;

    if (Timeout < 1) begin : g_timeout_check
        $error("Timeout must be at least 1");
    end

    assign pop         = (state == S_FEED) && !bus.Fifo_Empty;
    assign bus.Fifo_Rd = pop;
    assign out_full    = (out_cnt == OUT_W'(N_OUT));
    assign accept      = bus.Pool_Valid_OUT && !out_full &&
                         (state == S_FEED || state == S_FLUSH || state == S_WAIT);
    assign ch_next     = ch_cnt + 1'b1;
    assign Busy        = (state != S_IDLE);
    assign Done        = (state == S_FINISH);

`ifdef POOL_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(Timeout + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            error_q;

    assign timed_out = (state == S_WAIT) && !out_full && (wd_cnt == WD_W'(Timeout - 1));
    assign Error     = error_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            wd_cnt  <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == S_IDLE && Start)
                error_q <= 1'b0;
            else if (timed_out)
                error_q <= 1'b1;
            if (state != S_WAIT || accept)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign Error     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state             <= S_IDLE;
            num_ch            <= '0;
            ch_cnt            <= '0;
            pix_cnt           <= '0;
            out_cnt           <= '0;
            flush_cnt         <= '0;
            bus.Pool_In       <= '0;
            bus.Pool_Valid_IN <= 1'b0;
            bus.Pool_CLR      <= 1'b0;
            bus.Out_Data      <= '0;
            bus.Out_Valid     <= 1'b0;
        end else begin
            bus.Pool_Valid_IN <= 1'b0;
            bus.Pool_CLR      <= 1'b0;
            bus.Out_Valid     <= 1'b0;

            // Results are collected independently of the feed so a final pop and a result can coincide.
            if (accept) begin
                bus.Out_Data  <= bus.Pool_Out;
                bus.Out_Valid <= 1'b1;
                out_cnt       <= out_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (Start) begin
                        num_ch <= Num_Channels;
                        ch_cnt <= '0;
                        state  <= (Num_Channels == '0) ? S_FINISH : S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    bus.Pool_CLR <= 1'b1;
                    pix_cnt      <= '0;
                    out_cnt      <= '0;
                    flush_cnt    <= '0;
                    state        <= S_FEED;
                end
                S_FEED: begin
                    if (pop) begin
                        bus.Pool_In       <= bus.Fifo_Data;
                        bus.Pool_Valid_IN <= 1'b1;
                        pix_cnt           <= pix_cnt + 1'b1;
                        if (pix_cnt == PIX_W'(N_PIX - 1))
                            state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    bus.Pool_In       <= '0;
                    bus.Pool_Valid_IN <= 1'b1;
                    flush_cnt         <= flush_cnt + 1'b1;
                    if (flush_cnt == FL_W'(N_FLUSH - 1))
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (timed_out)
                        state <= S_FINISH;
                    else if (out_full)
                        state <= S_NEXT;
                end
                S_NEXT: begin
                    ch_cnt <= ch_next;
                    state  <= (ch_next == num_ch) ? S_FINISH : S_CLEAR;
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maxpool_frame_sequencer.sv
// Bench for maxpool_frame_sequencer: FIFO and pool-engine models, reference pooling, per-cycle compare.
`timescale 1ns/1ps
module tb_maxpool_frame_sequencer;
    localparam int W       = 4;
    localparam int H       = 4;
    localparam int DW      = 16;
    localparam int S       = 2;
    localparam int MAXC    = 64;
    localparam int TO      = 50;
    localparam int N_PIX   = W * H;
    localparam int N_FLUSH = W + 1;
    localparam int N_OUT   = ((W + S - 1) / S) * ((H + S - 1) / S);
    localparam int CHW     = $clog2(MAXC + 1);

    typedef logic signed [DW-1:0] map_t [N_PIX];
    typedef struct packed { logic signed [DW-1:0] d; logic real_px; } pix_t;

    logic           CLK = 1'b0;
    logic           CLR = 1'b1;
    logic           Start = 1'b0;
    logic [CHW-1:0] Num_Channels = '0;
    logic           Busy, Done, Error;

    maxpool_frame_sequencer_if #(.Datawidth(DW)) bus ();

    maxpool_frame_sequencer #(
        .IMG_Width(W), .IMG_Height(H), .Datawidth(DW), .Stride(S),
        .Max_Channels(MAXC), .Timeout(TO)
    ) dut (
        .CLK(CLK), .CLR(CLR), .Start(Start), .Num_Channels(Num_Channels),
        .Busy(Busy), .Done(Done), .Error(Error), .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Max over the 3x3 window centred at (r,c); pixels outside the map count as zero.
    function automatic int pool_at(input map_t m, input int r, input int c);
        int best = -(1 << 30);
        int v;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                if (r + dr < 0 || r + dr >= H || c + dc < 0 || c + dc >= W) v = 0;
                else v = int'(m[(r + dr) * W + c + dc]);
                if (v > best) best = v;
            end
        return best;
    endfunction

    // Input FIFO (first-word fall-through)
    logic signed [DW-1:0] fifo_mem [0:1023];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic gap = 1'b0;
    logic gap_en = 1'b0;
    assign bus.Fifo_Data  = fifo_mem[rd_ptr % 1024];
    assign bus.Fifo_Empty = (rd_ptr == wr_ptr) || gap;
    always @(posedge CLK) if (bus.Fifo_Rd) rd_ptr <= rd_ptr + 1;
    always @(posedge CLK) begin
        #1;
        gap = gap_en ? ~gap : 1'b0;
    end

    // Pool engine: result for centre (r,c) appears one cycle after stream index r*W+c+W+1 arrives.
    map_t eng_img;
    int   eng_cnt = 0;
    logic eng_mute = 1'b0;
    always @(posedge CLK) begin
        if (CLR || bus.Pool_CLR) begin
            eng_cnt = 0;
            bus.Pool_Valid_OUT <= 1'b0;
            bus.Pool_Out       <= '0;
        end else begin
            bus.Pool_Valid_OUT <= 1'b0;
            if (bus.Pool_Valid_IN) begin
                if (eng_cnt < N_PIX) eng_img[eng_cnt] = bus.Pool_In;
                for (int r = 0; r < H; r += S)
                    for (int c = 0; c < W; c += S)
                        if (r * W + c + W + 1 == eng_cnt && !eng_mute) begin
                            bus.Pool_Valid_OUT <= 1'b1;
                            bus.Pool_Out       <= DW'(pool_at(eng_img, r, c));
                        end
                eng_cnt = eng_cnt + 1;
            end
        end
    end

    // Scoreboard
    pix_t pix_q[$];
    int   exp_q[$];
    pix_t cur_px;
    int   got [0:1023];
    int   out_total = 0, vin_total = 0, done_total = 0, clr_total = 0, rd_total = 0;
    logic rd_prev = 1'b0;

    always @(negedge CLK) begin
        if (CLR) begin
            rd_prev = 1'b0;
        end else begin
            if (bus.Out_Valid) begin
                got[out_total % 1024] = int'($signed(bus.Out_Data));
                out_total++;
                check("out_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("out_data", int'($signed(bus.Out_Data)), exp_q.pop_front());
            end
            if (bus.Pool_Valid_IN) begin
                vin_total++;
                check("vin_expected", int'(pix_q.size() > 0), 1);
                if (pix_q.size() > 0) begin
                    cur_px = pix_q.pop_front();
                    check("pool_in", int'($signed(bus.Pool_In)), int'(cur_px.d));
                    if (cur_px.real_px) check("vin_after_pop", int'(rd_prev), 1);
                end
            end
            if (Done) done_total++;
            if (bus.Pool_CLR) clr_total++;
            if (bus.Fifo_Rd) rd_total++;
            rd_prev = bus.Fifo_Rd;
        end
    end

    int s_out, s_vin, s_done, s_clr, s_rd;
    task automatic snap();
        s_out = out_total; s_vin = vin_total; s_done = done_total; s_clr = clr_total; s_rd = rd_total;
    endtask

    task automatic make_ramp(input int off, output map_t m);
        for (int i = 0; i < N_PIX; i++) m[i] = DW'(i + 1 + off);
    endtask

    task automatic push_map(input map_t m);
        for (int i = 0; i < N_PIX; i++) begin
            fifo_mem[wr_ptr % 1024] = m[i];
            wr_ptr++;
            pix_q.push_back('{d: m[i], real_px: 1'b1});
        end
        for (int i = 0; i < N_FLUSH; i++) pix_q.push_back('{d: '0, real_px: 1'b0});
        for (int r = 0; r < H; r += S)
            for (int c = 0; c < W; c += S) exp_q.push_back(pool_at(m, r, c));
    endtask

    task automatic start_run(input int nch);
        @(posedge CLK); #1;
        Num_Channels = CHW'(nch);
        Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        do begin @(negedge CLK); k++; end while (!Done && k < budget);
        check({tag, "_done_seen"}, int'(Done), 1);
        @(negedge CLK);
        check({tag, "_busy_low"}, int'(Busy), 0);
        @(posedge CLK); #1;
    endtask

    task automatic check_run(input string tag, input int rd, input int clr, input int outs, input int vin);
        check({tag, "_fifo_rd"}, rd_total - s_rd, rd);
        check({tag, "_pool_clr"}, clr_total - s_clr, clr);
        check({tag, "_out_count"}, out_total - s_out, outs);
        check({tag, "_vin_count"}, vin_total - s_vin, vin);
        check({tag, "_done_count"}, done_total - s_done, 1);
        check({tag, "_exp_left"}, exp_q.size() + pix_q.size(), 0);
    endtask

    task automatic abort_clear();
        @(posedge CLK); #1;
        CLR = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        pix_q.delete();
        exp_q.delete();
        wr_ptr = rd_ptr;
        eng_mute = 1'b0;
        CLR = 1'b0;
    endtask

    int lit_ramp [4] = '{6, 8, 14, 16};
    int lit_neg  [4] = '{0, 0, 0, -5};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        map_t m;
        int k;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        check("rst_error", int'(Error), 0);
        check("rst_fifo_rd", int'(bus.Fifo_Rd), 0);
        check("rst_pool_vin", int'(bus.Pool_Valid_IN), 0);
        check("rst_pool_clr", int'(bus.Pool_CLR), 0);
        check("rst_pool_in", int'(bus.Pool_In), 0);
        check("rst_out_valid", int'(bus.Out_Valid), 0);
        check("rst_out_data", int'(bus.Out_Data), 0);
        @(posedge CLK); #1;
        CLR = 1'b0;

        // single channel, ramp 1..16
        make_ramp(0, m);
        for (int i = 0; i < 4; i++) check("model_pin_ramp", pool_at(m, (i / 2) * 2, (i % 2) * 2), lit_ramp[i]);
        snap();
        push_map(m);
        start_run(1);
        wait_done("ramp", 500);
        check_run("ramp", 16, 1, 4, 21);
        for (int i = 0; i < 4; i++) check("ramp_literal", got[(s_out + i) % 1024], lit_ramp[i]);

        // three channels with +100 offsets, plus an ignored Start while busy
        snap();
        for (int ch = 0; ch < 3; ch++) begin
            make_ramp(100 * ch, m);
            push_map(m);
        end
        start_run(3);
        repeat (10) @(posedge CLK);
        #1;
        Num_Channels = CHW'(1);
        Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        wait_done("multi", 1000);
        check_run("multi", 48, 3, 12, 63);
        check("multi_literal_ch1", got[(s_out + 4) % 1024], 106);
        check("multi_literal_ch2", got[(s_out + 11) % 1024], 216);

        // FIFO bubbles every other cycle
        make_ramp(0, m);
        snap();
        push_map(m);
        gap_en = 1'b1;
        start_run(1);
        wait_done("bubble", 500);
        gap_en = 1'b0;
        check_run("bubble", 16, 1, 4, 21);
        for (int i = 0; i < 4; i++) check("bubble_literal", got[(s_out + i) % 1024], lit_ramp[i]);

        // all pixels -5: padding wins everywhere except the interior window
        for (int i = 0; i < N_PIX; i++) m[i] = -16'sd5;
        for (int i = 0; i < 4; i++) check("model_pin_neg", pool_at(m, (i / 2) * 2, (i % 2) * 2), lit_neg[i]);
        snap();
        push_map(m);
        start_run(1);
        wait_done("neg", 500);
        check_run("neg", 16, 1, 4, 21);
        for (int i = 0; i < 4; i++) check("neg_literal", got[(s_out + i) % 1024], lit_neg[i]);

        // zero channels: straight to a Done pulse
        snap();
        start_run(0);
        wait_done("zero_ch", 20);
        check("zero_ch_clr", clr_total - s_clr, 0);
        check("zero_ch_rd", rd_total - s_rd, 0);
        check("zero_ch_done", done_total - s_done, 1);

        // abort mid-FEED, then a clean rerun
        make_ramp(0, m);
        snap();
        push_map(m);
        start_run(1);
        k = 0;
        while (rd_total - s_rd < 6 && k < 100) begin @(negedge CLK); k++; end
        check("abort_reached_feed", int'(rd_total - s_rd >= 6), 1);
        abort_clear();
        repeat (5) @(negedge CLK);
        check("abort_no_done", done_total - s_done, 0);
        check("abort_busy", int'(Busy), 0);
        snap();
        push_map(m);
        start_run(1);
        wait_done("rerun", 500);
        check_run("rerun", 16, 1, 4, 21);
        for (int i = 0; i < 4; i++) check("rerun_literal", got[(s_out + i) % 1024], lit_ramp[i]);

        // silent engine
        make_ramp(0, m);
        snap();
        push_map(m);
        exp_q.delete();
        eng_mute = 1'b1;
        start_run(1);
`ifdef POOL_SEQ_TIMEOUT_EN
        wait_done("timeout", 300);
        check("timeout_error", int'(Error), 1);
        check("timeout_outs", out_total - s_out, 0);
        check("timeout_done_count", done_total - s_done, 1);
        eng_mute = 1'b0;
`else
        repeat (150) @(negedge CLK);
        check("stall_busy", int'(Busy), 1);
        check("stall_error", int'(Error), 0);
        check("stall_no_done", done_total - s_done, 0);
        check("stall_fifo_rd", rd_total - s_rd, 16);
        abort_clear();
        @(negedge CLK);
        check("stall_cleared", int'(Busy), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
